// File: rtl/gpio_step_sequencer.sv
// rtl/gpio_step_sequencer.sv - scripted expect/drive/echo sequencer for a split GPIO bus
//
// Runs a table of steps. Each step waits for the upper bus half to show an
// expected pattern, drives the lower half, then waits for the pad loopback to
// echo the driven value. A per-step timeout and an abort pulse end the script
// early, and the outcome is reported on done/pass/fail_step.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   cfg_we     step-table write strobe (ignored while busy)
//   cfg_addr   step-table write index
//   cfg_wdata  table entry {last, expect[WIDTH-1:0], drive[WIDTH-1:0]}
//   start      one-cycle pulse, runs the script from step 0
//   abort      one-cycle pulse, stops the script
//   gpio_in    pad inputs: [2W-1:W] expect half, [W-1:0] loopback half
//   gpio_out   driven value for the lower half
//   gpio_oe    output enable for the lower half
//   busy       script running
//   done       script finished (sticky until next start)
//   pass       clean completion, valid while done=1
//   fail_step  step index of the last timeout
module gpio_step_sequencer #(
  parameter int WIDTH          = 8,
  parameter int STEPS          = 8,
  parameter int TIMEOUT_CYCLES = 25000,
  localparam int AW            = $clog2(STEPS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [2*WIDTH:0]   cfg_wdata,
  input  logic               start,
  input  logic               abort,
  input  logic [2*WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0]   gpio_out,
  output logic               gpio_oe,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [AW-1:0]      fail_step
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] STEP_MAX = AW'(STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EXP,
    S_DRIVE,
    S_ECHO,
    S_FINISH
  } state_t;

  state_t              state;
  logic [2*WIDTH:0]    tbl [STEPS];
  logic [2*WIDTH-1:0]  sync1;
  logic [2*WIDTH-1:0]  sin;
  logic [AW-1:0]       step;
  logic [31:0]         timer;

  logic [2*WIDTH:0]    cur;
  logic                cur_last;
  logic [WIDTH-1:0]    cur_exp;
  logic [WIDTH-1:0]    cur_drv;
  logic                exp_match;
  logic                echo_match;
  logic                to_hit;
  logic [31:0]         timer_inc;

  assign cur        = tbl[step];
  assign cur_last   = cur[2*WIDTH];
  assign cur_exp    = cur[2*WIDTH-1:WIDTH];
  assign cur_drv    = cur[WIDTH-1:0];
  assign exp_match  = (sin[2*WIDTH-1:WIDTH] == cur_exp);
  assign echo_match = (sin[WIDTH-1:0] == gpio_out);
  assign to_hit     = TO_EN && (timer == TO_LAST);
  // Saturating increment so a disabled timeout never sees the counter wrap.
  assign timer_inc  = (timer == 32'hFFFF_FFFF) ? timer : timer + 32'd1;

  // Two-flop synchroniser; all pattern compares use sin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sin   <= '0;
    end else begin
      sync1 <= gpio_in;
      sin   <= sync1;
    end
  end

  // Step table; frozen while a script is running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) tbl[i] <= '0;
    end else if (cfg_we && !busy) begin
      tbl[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      step      <= '0;
      timer     <= '0;
      gpio_out  <= '0;
      gpio_oe   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_step <= '0;
    end else if (abort && state != S_IDLE) begin
      // Abort overrides everything, including a pass already latched.
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b1;
      pass    <= 1'b0;
      gpio_oe <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            step  <= '0;
            timer <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
            state <= S_WAIT_EXP;
          end
        end
        S_WAIT_EXP: begin
          if (exp_match) begin
            timer <= '0;
            state <= S_DRIVE;
          end else if (to_hit) begin
            fail_step <= step;
            pass      <= 1'b0;
            state     <= S_FINISH;
          end else begin
            timer <= timer_inc;
          end
        end
        S_DRIVE: begin
          gpio_out <= cur_drv;
          gpio_oe  <= 1'b1;
          state    <= S_ECHO;
        end
        S_ECHO: begin
          if (echo_match) begin
            // The last table slot ends the script even without its last flag.
            if (cur_last || step == STEP_MAX) begin
              pass  <= 1'b1;
              state <= S_FINISH;
            end else begin
              step  <= step + AW'(1);
              timer <= '0;
              state <= S_WAIT_EXP;
            end
          end else if (to_hit) begin
            fail_step <= step;
            pass      <= 1'b0;
            state     <= S_FINISH;
          end else begin
            timer <= timer_inc;
          end
        end
        S_FINISH: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          gpio_oe <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_step_sequencer.sv
// tb/tb_gpio_step_sequencer.sv - bench for gpio_step_sequencer
module tb_gpio_step_sequencer;

  localparam int W  = 8;
  localparam int ST = 8;
  localparam int TO = 100;
  localparam int AW = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            cfg_we = 1'b0;
  logic [AW-1:0]   cfg_addr = '0;
  logic [2*W:0]    cfg_wdata = '0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [2*W-1:0]  gpio_in = '0;
  logic [W-1:0]    gpio_out;
  logic            gpio_oe;
  logic            busy;
  logic            done;
  logic            pass;
  logic [AW-1:0]   fail_step;

  gpio_step_sequencer #(.WIDTH(W), .STEPS(ST), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .abort(abort), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .busy(busy), .done(done),
    .pass(pass), .fail_step(fail_step)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: the script as sequential code ----------------
  logic [2*W:0]   m_tbl [ST];
  logic [2*W-1:0] h1 = '0, h2 = '0;
  logic [W-1:0]   sin_hi, sin_lo;
  logic           s_start, s_abort;
  int             m_step = 0;
  bit             m_in_echo = 0;
  logic [W-1:0]   e_out = '0;
  logic           e_oe = 0, e_busy = 0, e_done = 0, e_pass = 0;
  logic [AW-1:0]  e_fail = '0;

  task automatic step_clk();
    @(posedge clock);
    sin_hi  = h2[2*W-1:W];
    sin_lo  = h2[W-1:0];
    h2      = h1;
    h1      = gpio_in;
    s_start = start;
    s_abort = abort;
    if (cfg_we && !e_busy) m_tbl[cfg_addr] = cfg_wdata;
  endtask

  task automatic do_abort();
    e_busy = 0; e_done = 1; e_pass = 0; e_oe = 0;
  endtask

  task automatic finish_cycle();
    step_clk();
    if (s_abort) do_abort();
    else begin e_busy = 0; e_done = 1; e_oe = 0; end
  endtask

  task automatic run_script();
    int s = 0;
    int n;
    forever begin
      m_step = s; m_in_echo = 0; n = 0;
      forever begin
        step_clk();
        if (s_abort) begin do_abort(); return; end
        if (sin_hi == m_tbl[s][2*W-1:W]) break;
        if (n == TO - 1) begin e_fail = AW'(s); e_pass = 0; finish_cycle(); return; end
        n++;
      end
      step_clk();
      if (s_abort) begin do_abort(); return; end
      e_out = m_tbl[s][W-1:0]; e_oe = 1;
      m_in_echo = 1; n = 0;
      forever begin
        step_clk();
        if (s_abort) begin do_abort(); return; end
        if (sin_lo == e_out) begin
          if (m_tbl[s][2*W] || s == ST - 1) begin e_pass = 1; finish_cycle(); return; end
          s++;
          break;
        end
        if (n == TO - 1) begin e_fail = AW'(s); e_pass = 0; finish_cycle(); return; end
        n++;
      end
    end
  endtask

  initial begin : model
    for (int i = 0; i < ST; i++) m_tbl[i] = '0;
    wait (reset == 1'b0);
    forever begin
      m_in_echo = 0;
      step_clk();
      if (s_start && !s_abort) begin
        e_busy = 1; e_done = 0; e_pass = 0;
        run_script();
        m_in_echo = 0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin : compare
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("gpio_out", 32'(gpio_out), 32'(e_out));
        chk("gpio_oe", 32'(gpio_oe), 32'(e_oe));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("fail_step", 32'(fail_step), 32'(e_fail));
        if (e_done) chk("pass", 32'(pass), 32'(e_pass));
      end
    end
  end

  // ---------------- pad driver / responder ----------------
  int           resp_mode = 0;   // 0 hold, 1 correct, 2 noisy, 3 never correct
  logic [W-1:0] hi_val = '0;
  bit           lb_force = 0;
  logic [W-1:0] lb_val = '0;

  initial begin : pads
    logic [W-1:0] want;
    logic [W-1:0] lb;
    forever begin
      @(negedge clock);
      want = m_tbl[m_step][2*W-1:W];
      case (resp_mode)
        1: hi_val = want;
        2: hi_val = ($urandom_range(3, 0) != 0) ? want : W'($urandom);
        3: hi_val = ~want;
        default: ;
      endcase
      if (lb_force) lb = lb_val;
      else if (resp_mode == 2 && $urandom_range(19, 0) == 0) lb = W'($urandom);
      else lb = gpio_out;
      gpio_in = {hi_val, lb};
    end
  end

  // Records each newly driven value while the output is enabled.
  logic [W-1:0] drv_q[$];
  initial begin : drv_mon
    logic         prev_oe = 0;
    logic [W-1:0] prev_out = '0;
    forever begin
      @(negedge clock);
      if (gpio_oe && (!prev_oe || gpio_out != prev_out)) drv_q.push_back(gpio_out);
      prev_oe = gpio_oe;
      prev_out = gpio_out;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg_write(input int a, input logic [2*W:0] d);
    @(negedge clock);
    cfg_we = 1; cfg_addr = AW'(a); cfg_wdata = d;
    @(negedge clock);
    cfg_we = 0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
  endtask

  task automatic wait_done(input string nm, input int max, output int cyc);
    cyc = 0;
    while (!done && cyc < max) begin
      @(negedge clock);
      cyc++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=done0 expected=done1", nm);
    end
  endtask

  task automatic wait_step(input string nm, input int s, input bit echo);
    int k = 0;
    while (!(m_step == s && (m_in_echo || !echo) && e_busy) && k < 1000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 1000) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=notreached expected=step%0d", nm, s);
    end
  endtask

  task automatic load_basic();
    cfg_write(0, {1'b0, 8'hA0, 8'hF0});
    cfg_write(1, {1'b0, 8'h0B, 8'h0F});
    cfg_write(2, {1'b1, 8'hAB, 8'h00});
  endtask

  int cyc;

  initial begin : main
    repeat (3) @(negedge clock);
    chk("rst_gpio_out", 32'(gpio_out), 0);
    chk("rst_gpio_oe", 32'(gpio_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_fail_step", 32'(fail_step), 0);
    reset = 0;
    chk_en = 1;

    // 1) three-step script with loopback
    load_basic();
    resp_mode = 1;
    drv_q.delete();
    pulse_start();
    wait_done("t1", 2000, cyc);
    chk("t1_ndrv", 32'(drv_q.size()), 3);
    if (drv_q.size() == 3) begin
      chk("t1_drv0", 32'(drv_q[0]), 32'h0F0);
      chk("t1_drv1", 32'(drv_q[1]), 32'h00F);
      chk("t1_drv2", 32'(drv_q[2]), 32'h000);
    end
    chk("t1_pass", 32'(pass), 1);

    // 2) expect pattern never shown: timeout decided on the 100th edge,
    //    FINISH registers done on the 101st
    resp_mode = 0; hi_val = 8'h00;
    repeat (3) @(negedge clock);
    pulse_start();
    wait_done("t2", 500, cyc);
    chk("t2_cycles", 32'(cyc), 101);
    chk("t2_pass", 32'(pass), 0);
    chk("t2_fail_step", 32'(fail_step), 0);
    chk("t2_oe", 32'(gpio_oe), 0);

    // 3) loopback stuck at 00 while step 1 drives 0F
    resp_mode = 1;
    pulse_start();
    wait_step("t3", 1, 0);
    lb_force = 1; lb_val = 8'h00;
    wait_done("t3", 2000, cyc);
    chk("t3_fail_step", 32'(fail_step), 1);
    chk("t3_pass", 32'(pass), 0);
    lb_force = 0;

    // 4) abort together with start during ECHO of step 1
    pulse_start();
    wait_step("t4", 1, 0);
    lb_force = 1; lb_val = 8'h00;
    wait_step("t4", 1, 1);
    repeat (3) @(negedge clock);
    abort = 1; start = 1;
    @(negedge clock);
    abort = 0; start = 0;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_done", 32'(done), 1);
    chk("t4_pass", 32'(pass), 0);
    chk("t4_oe", 32'(gpio_oe), 0);
    lb_force = 0;
    drv_q.delete();
    repeat (2) @(negedge clock);
    pulse_start();
    wait_done("t4b", 2000, cyc);
    chk("t4_rerun_first", (drv_q.size() > 0) ? 32'(drv_q[0]) : 32'hDEAD, 32'h0F0);
    chk("t4_rerun_pass", 32'(pass), 1);

    // 5) no last flags: ends after the final slot
    for (int i = 0; i < ST; i++) cfg_write(i, {1'b0, 8'(8'h11 * i), 8'(8'h80 + i)});
    drv_q.delete();
    pulse_start();
    wait_done("t5", 4000, cyc);
    chk("t5_ndrv", 32'(drv_q.size()), 8);
    chk("t5_lastdrv", (drv_q.size() > 0) ? 32'(drv_q[$]) : 32'hDEAD, 32'h087);
    chk("t5_pass", 32'(pass), 1);

    // 6) table write while busy is ignored; after done it lands
    load_basic();
    drv_q.delete();
    pulse_start();
    cfg_write(2, {1'b1, 8'hCC, 8'h33});
    wait_done("t6", 2000, cyc);
    chk("t6_drv2_orig", (drv_q.size() == 3) ? 32'(drv_q[2]) : 32'hDEAD, 32'h000);
    cfg_write(2, {1'b1, 8'hCC, 8'h33});
    drv_q.delete();
    pulse_start();
    wait_done("t6b", 2000, cyc);
    chk("t6_drv2_new", (drv_q.size() == 3) ? 32'(drv_q[2]) : 32'hDEAD, 32'h033);
    chk("t6_pass", 32'(pass), 1);

    // randomized scripts with aborts, stray starts and blocked writes
    for (int r = 0; r < 30; r++) begin
      int mode;
      for (int i = 0; i < ST; i++)
        cfg_write(i, {($urandom_range(2, 0) == 0), 8'($urandom), 8'($urandom)});
      mode = $urandom_range(9, 0);
      resp_mode = (mode == 0) ? 3 : 2;
      lb_force = (mode == 1);
      lb_val = 8'($urandom);
      pulse_start();
      cyc = 0;
      forever begin
        @(negedge clock);
        cyc++;
        abort = 0; start = 0; cfg_we = 0;
        if (done || cyc >= 4000) break;
        abort = ($urandom_range(199, 0) == 0);
        start = ($urandom_range(29, 0) == 0);
        cfg_we = ($urandom_range(14, 0) == 0);
        cfg_addr = AW'($urandom);
        cfg_wdata = (2*W+1)'($urandom);
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL rand_run%0d timeout actual=done0 expected=done1", r);
      end
      lb_force = 0;
    end

    // async reset mid-run drops gpio_oe without a clock edge
    load_basic();
    resp_mode = 1;
    pulse_start();
    lb_force = 1; lb_val = 8'h55;
    wait_step("rst_mid", 0, 1);
    @(negedge clock);
    chk("pre_reset_oe", 32'(gpio_oe), 1);
    chk_en = 0;
    @(posedge clock);
    #3 reset = 1;
    #1;
    chk("async_reset_oe", 32'(gpio_oe), 0);
    chk("async_reset_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
